// File: rtl/wb_arb2.sv
// wb_arb2: two-master, one-slave Wishbone arbiter.
// Round-robin between master 0 and master 1, with a watchdog that returns a
// single-cycle err to the granted master when the slave does not ack in time.
//
// Handshake: a master owns the bus from the first edge that samples its cyc
// high until cyc drops. Within a grant, a transfer completes in the cycle where
// stb and ack are both high. ack and err are combinational from the slave
// side, and only the granted master ever sees them.
module wb_arb2 #(
  parameter int adr_width = 32,
  parameter int timeout   = 255,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  // master 0
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  // master 1
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  // slave
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  // one-hot grant, also serves as the visible FSM state
  output logic [1:0]           gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Watchdog threshold in counter width; a zero timeout turns the watchdog off.
  localparam logic [cnt_width-1:0] TIMEOUT_C = cnt_width'(timeout);
  localparam bit                   WD_EN     = (timeout != 0);

  state_t               state_q, state_d;
  logic                 last_q, last_d;   // master served most recently
  logic [cnt_width-1:0] cnt_q, cnt_d;     // cycles of unacknowledged strobe

  logic gnt0, gnt1;
  logic cyc_raw, stb_raw;
  logic err_pulse;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Granted master's cyc/stb before the watchdog masks stb.
  always_comb begin
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    if (gnt0) begin
      cyc_raw = m0_cyc_i;
      stb_raw = m0_stb_i;
    end else if (gnt1) begin
      cyc_raw = m1_cyc_i;
      stb_raw = m1_stb_i;
    end
  end

  // An ack arriving in the timeout cycle wins, so err requires no ack.
  assign err_pulse = WD_EN && cyc_raw && stb_raw && !s_ack_i && (cnt_q == TIMEOUT_C);

  // Next grant: round-robin from IDLE, hold while cyc, hand over without an IDLE gap.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Watchdog counter: counts strobe cycles without ack, restarts after an err.
  always_comb begin
    cnt_d = '0;
    if (WD_EN && cyc_raw && stb_raw && !s_ack_i && !err_pulse) begin
      cnt_d = cnt_q + cnt_width'(1);
    end
  end

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slave-side mux, driven purely from the registered grant; zero when idle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    case (state_q)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~err_pulse;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~err_pulse;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Return path: read data is broadcast, ack/err only to the granted master.
  always_comb begin
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = s_ack_i & gnt0 & m0_stb_i;
    m1_ack_o = s_ack_i & gnt1 & m1_stb_i;
    m0_err_o = err_pulse & gnt0;
    m1_err_o = err_pulse & gnt1;
  end

  assign gnt_o = {gnt1, gnt0};

endmodule
